// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                   |
// | Brief    : Arbitrates an instruction-fetch port and a load/store port    |
// |            onto one downstream memory port. The downstream request is    |
// |            registered and held for the whole transaction; a busy-cycle   |
// |            watchdog aborts transactions that never see mem_ready.        |
// | Options  : MEM_ARB_RR_EN - round-robin between fetch and data when both  |
// |            request together (default build: data has fixed priority).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    // fetch port
    input  logic        i_read_valid,
    input  logic [31:0] i_addr,
    output logic [31:0] i_read_data,
    output logic        i_ready,
    output logic        i_err,
    // data port
    input  logic        d_read_valid,
    input  logic        d_write_valid,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_width,
    input  logic [31:0] d_write_data,
    output logic [31:0] d_read_data,
    output logic        d_ready,
    output logic        d_err,
    // downstream memory port
    output logic        mem_read_valid,
    output logic        mem_write_valid,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_width,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready
);

    localparam int                 c_cnt_w   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT_CYCLES);
    localparam bit                 c_wd_en   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_mem_read_valid;
    logic               r_mem_write_valid;
    logic [31:0]        r_mem_addr;
    logic [1:0]         r_mem_width;
    logic [31:0]        r_mem_write_data;

    logic               w_req_d;
    logic               w_grant_d;
    logic               w_timeout;
    logic               w_busy_i;
    logic               w_busy_d;

    assign w_req_d = d_read_valid | d_write_valid;

`ifdef MEM_ARB_RR_EN
    // Remembers whether the most recent grant went to the data port.
    logic r_last_d;
    assign w_grant_d = w_req_d & (~i_read_valid | ~r_last_d);
`else
    assign w_grant_d = w_req_d;
`endif

    assign w_timeout = c_wd_en & (r_cnt == c_timeout);

    // Completion/abort strobes are combinational from mem_ready and are
    // masked during reset so an abandoned transaction never reports.
    assign w_busy_i = ~rst & (r_state == BUSY_I);
    assign w_busy_d = ~rst & (r_state == BUSY_D);

    assign i_ready     = w_busy_i & mem_ready;
    assign i_err       = w_busy_i & ~mem_ready & w_timeout;
    assign i_read_data = i_ready ? mem_read_data : 32'd0;

    assign d_ready     = w_busy_d & mem_ready;
    assign d_err       = w_busy_d & ~mem_ready & w_timeout;
    assign d_read_data = d_ready ? mem_read_data : 32'd0;

    assign mem_read_valid  = r_mem_read_valid;
    assign mem_write_valid = r_mem_write_valid;
    assign mem_addr        = r_mem_addr;
    assign mem_width       = r_mem_width;
    assign mem_write_data  = r_mem_write_data;

    // Arbitration FSM: capture the winning request in IDLE, hold it while
    // busy, release on mem_ready (which beats a same-cycle timeout).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= IDLE;
            r_cnt             <= '0;
            r_mem_read_valid  <= 1'b0;
            r_mem_write_valid <= 1'b0;
            r_mem_addr        <= 32'd0;
            r_mem_width       <= 2'b00;
            r_mem_write_data  <= 32'd0;
`ifdef MEM_ARB_RR_EN
            r_last_d          <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_read_valid || w_req_d) begin
                        r_cnt <= '0;
`ifdef MEM_ARB_RR_EN
                        r_last_d <= w_grant_d;
`endif
                        if (w_grant_d) begin
                            // A simultaneous read+write request is a write.
                            r_state           <= BUSY_D;
                            r_mem_read_valid  <= ~d_write_valid;
                            r_mem_write_valid <= d_write_valid;
                            r_mem_addr        <= d_addr;
                            r_mem_width       <= d_width;
                            r_mem_write_data  <= d_write_data;
                        end else begin
                            r_state           <= BUSY_I;
                            r_mem_read_valid  <= 1'b1;
                            r_mem_write_valid <= 1'b0;
                            r_mem_addr        <= i_addr;
                            r_mem_width       <= 2'b10;
                            r_mem_write_data  <= 32'd0;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ready || w_timeout) begin
                        r_state           <= IDLE;
                        r_cnt             <= '0;
                        r_mem_read_valid  <= 1'b0;
                        r_mem_write_valid <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state           <= IDLE;
                    r_mem_read_valid  <= 1'b0;
                    r_mem_write_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
